// File: rtl/midi_uart_tx_if.sv
// Byte handshake between the synth control logic (master) and the MIDI UART transmitter (slave).
interface midi_uart_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/midi_uart_tx.sv
// MIDI 8N1 UART transmitter with byte FIFO; true-polarity txd, idle high.
// Define MIDI_RUNNING_STATUS_EN to drop repeated channel-status bytes (running status).
module midi_uart_tx #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 31250,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        CLOCK_50,
  input  logic                        reset_n,
  midi_uart_tx_if.slave               tx_if,
  output logic                        txd,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
  localparam int DIV   = CLK_FREQ / BAUD;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(DIV - 1);
  localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state_q, state_d;
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             txd_q, txd_d;
  logic             push, pop, drop, baud_done;
  logic [7:0]       head;

  assign tx_if.tx_ready = (count_q != LVL_FULL);
  assign push           = tx_if.tx_valid && tx_if.tx_ready;
  assign head           = mem_q[rd_ptr_q];
  assign baud_done      = (baud_q == BAUD_LAST);

`ifdef MIDI_RUNNING_STATUS_EN
  logic [7:0] last_status_q, last_status_d;

  assign drop = (head >= 8'h80) && (head <= 8'hEF) && (head == last_status_q);

  always_comb begin
    last_status_d = last_status_q;
    if (pop) begin
      if ((head >= 8'h80) && (head <= 8'hEF)) begin
        last_status_d = head;
      end else if ((head >= 8'hF0) && (head <= 8'hF7)) begin
        last_status_d = 8'h00;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      last_status_q <= 8'h00;
    end else begin
      last_status_q <= last_status_d;
    end
  end
`else
  assign drop = 1'b0;
`endif

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop = 1'b1;
          if (!drop) begin
            state_d = START;
            shift_d = head;
            baud_d  = '0;
          end
        end
      end
      START: begin
        if (baud_done) begin
          state_d = DATA;
          baud_d  = '0;
          bit_d   = 3'd0;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      STOP: begin
        if (baud_done) begin
          state_d = IDLE;
          baud_d  = '0;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // txd is registered from the next state so the line changes on the same edge as the FSM.
    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      baud_q   <= '0;
      bit_q    <= 3'd0;
      shift_q  <= 8'h00;
      txd_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      txd_q    <= txd_d;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (push) mem_q[wr_ptr_q] <= tx_if.tx_data;
  end

  assign txd        = txd_q;
  assign busy       = (state_q != IDLE) || (count_q != '0);
  assign fifo_level = count_q;

endmodule

// File: tb/tb_midi_uart_tx.sv
// Self-checking bench for midi_uart_tx: a UART line decoder plus a byte-list model of what must appear on txd.
// Runs a reduced clock/baud ratio (DIV=16) so that multi-frame scenarios stay short.
module tb_midi_uart_tx;
  localparam int CLK_FREQ   = 500000;
  localparam int BAUD       = 31250;
  localparam int FIFO_DEPTH = 16;
  localparam int DIV        = CLK_FREQ / BAUD;
  localparam int FRAME      = 10 * DIV;
  localparam int PERIOD     = 10;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       txd;
  logic       busy;
  logic [4:0] fifo_level;

  midi_uart_tx_if tx_if();

  midi_uart_tx #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .CLOCK_50  (clk),
    .reset_n   (reset_n),
    .tx_if     (tx_if),
    .txd       (txd),
    .busy      (busy),
    .fifo_level(fifo_level)
  );

  always #(PERIOD / 2) clk = ~clk;

  int         tests = 0;
  int         fails = 0;
  int         timeouts = 0;
  logic [7:0] exp_q[$];
  logic [7:0] model_last = 8'h00;

  // Line decoder: samples mid-bit, keeps the decoded bytes and start times.
  logic [7:0] rx_q[$];
  longint     rx_t[$];
  int         frame_err = 0;
  int         reset_count = 0;

  always @(negedge reset_n) reset_count <= reset_count + 1;

  initial begin : line_monitor
    logic [7:0] b;
    longint     t0;
    int         rc0;
    bit         ok;
    forever begin
      @(negedge txd);
      if (reset_n !== 1'b1) continue;
      t0  = longint'($time);
      rc0 = reset_count;
      ok  = 1'b1;
      repeat (DIV / 2) @(negedge clk);
      if (txd !== 1'b0) ok = 1'b0;
      for (int i = 0; i < 8; i++) begin
        repeat (DIV) @(negedge clk);
        b[i] = txd;
      end
      repeat (DIV) @(negedge clk);
      if (txd !== 1'b1) ok = 1'b0;
      if (reset_count == rc0 && reset_n === 1'b1) begin
        if (ok) begin
          rx_q.push_back(b);
          rx_t.push_back(t0);
        end else begin
          frame_err++;
        end
      end
    end
  end

  initial begin : watchdog
    #(PERIOD * 60000);
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  // Reference: which accepted bytes must reach the wire, in order.
  function automatic void model_push(input logic [7:0] b);
`ifdef MIDI_RUNNING_STATUS_EN
    if (b >= 8'h80 && b < 8'hF0) begin
      if (b == model_last) return;
      model_last = b;
    end else if (b >= 8'hF0 && b < 8'hF8) begin
      model_last = 8'h00;
    end
`endif
    exp_q.push_back(b);
  endfunction

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    int guard = 0;
    while (tx_if.tx_ready !== 1'b1 && guard < 20 * FRAME) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 20 * FRAME) timeouts++;
    tx_if.tx_data  = b;
    tx_if.tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_if.tx_valid = 1'b0;
    model_push(b);
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (busy !== 1'b0 && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= limit) timeouts++;
    idle_cycles(2);
  endtask

  task automatic do_reset();
    tx_if.tx_valid = 1'b0;
    reset_n = 1'b0;
    idle_cycles(3);
    reset_n = 1'b1;
    idle_cycles(FRAME + 2 * DIV);
    exp_q.delete();
    model_last = 8'h00;
  endtask

  task automatic test_reset();
    tx_if.tx_valid = 1'b0;
    tx_if.tx_data  = 8'h00;
    reset_n = 1'b0;
    idle_cycles(3);
    tests++; if (txd !== 1'b1) begin fails++; $display("[TB] FAIL reset_txd got %b want 1", txd); end
    tests++; if (tx_if.tx_ready !== 1'b1) begin fails++; $display("[TB] FAIL reset_ready got %b want 1", tx_if.tx_ready); end
    tests++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    tests++; if (fifo_level !== 5'd0) begin fails++; $display("[TB] FAIL reset_level got %0d want 0", fifo_level); end
    reset_n = 1'b1;
    idle_cycles(4);
    tests++; if (txd !== 1'b1 || busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_idle txd=%b busy=%b want 1/0", txd, busy); end
  endtask

  task automatic test_single_byte();
    logic [7:0] v = 8'h90;
    logic       exp;
    int         base, t0;
    do_reset();
    base = rx_q.size();
    t0   = timeouts;
    push_byte(v);
    tests++; if (fifo_level !== 5'd1) begin fails++; $display("[TB] FAIL single_level_push got %0d want 1", fifo_level); end
    tests++; if (txd !== 1'b1) begin fails++; $display("[TB] FAIL single_txd_pre got %b want 1", txd); end
    for (int k = 1; k <= FRAME; k++) begin
      @(posedge clk); #1;
      if (k <= DIV) exp = 1'b0;
      else if (k <= 9 * DIV) exp = v[(k - 1) / DIV - 1];
      else exp = 1'b1;
      tests++; if (txd !== exp) begin fails++; $display("[TB] FAIL single_txd cycle %0d got %b want %b", k, txd, exp); end
      if (k == 1) begin
        tests++; if (fifo_level !== 5'd0) begin fails++; $display("[TB] FAIL single_level_pop got %0d want 0", fifo_level); end
      end
      if (k == FRAME) begin
        tests++; if (busy !== 1'b1) begin fails++; $display("[TB] FAIL single_busy_stop got %b want 1", busy); end
      end
    end
    @(posedge clk); #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL single_busy_end got %b want 0", busy); end
    tests++; if (txd !== 1'b1) begin fails++; $display("[TB] FAIL single_txd_end got %b want 1", txd); end
    idle_cycles(DIV);
    tests++; if (rx_q.size() != base + 1) begin fails++; $display("[TB] FAIL single_count got %0d want 1", rx_q.size() - base); end
    else begin
      tests++; if (rx_q[base] !== v) begin fails++; $display("[TB] FAIL single_byte got %h want %h", rx_q[base], v); end
    end
    tests++; if (timeouts != t0) begin fails++; $display("[TB] FAIL single_timeout got %0d want %0d", timeouts, t0); end
  endtask

  task automatic test_back_to_back();
    int base, t0, fe0;
    longint gap;
    do_reset();
    base = rx_q.size();
    t0   = timeouts;
    fe0  = frame_err;
    push_byte(8'h90);
    tests++; if (fifo_level !== 5'd1) begin fails++; $display("[TB] FAIL b2b_level0 got %0d want 1", fifo_level); end
    push_byte(8'h3C);
    tests++; if (fifo_level !== 5'd1) begin fails++; $display("[TB] FAIL b2b_level1 got %0d want 1", fifo_level); end
    push_byte(8'h7F);
    tests++; if (fifo_level !== 5'd2) begin fails++; $display("[TB] FAIL b2b_level2 got %0d want 2", fifo_level); end
    wait_idle(4 * (FRAME + 1) + 50);
    tests++; if (rx_q.size() != base + exp_q.size()) begin fails++; $display("[TB] FAIL b2b_count got %0d want %0d", rx_q.size() - base, exp_q.size()); end
    else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        tests++; if (rx_q[base + i] !== exp_q[i]) begin fails++; $display("[TB] FAIL b2b_byte%0d got %h want %h", i, rx_q[base + i], exp_q[i]); end
      end
      for (int i = 1; i < 3; i++) begin
        gap = rx_t[base + i] - rx_t[base + i - 1];
        tests++; if (gap != longint'((FRAME + 1) * PERIOD)) begin fails++; $display("[TB] FAIL b2b_gap%0d got %0d want %0d", i, gap, (FRAME + 1) * PERIOD); end
      end
    end
    tests++; if (frame_err != fe0) begin fails++; $display("[TB] FAIL b2b_framing got %0d want %0d", frame_err, fe0); end
    tests++; if (timeouts != t0) begin fails++; $display("[TB] FAIL b2b_timeout got %0d want %0d", timeouts, t0); end
  endtask

  task automatic test_full_fifo();
    logic [7:0] bytes[18];
    int  base, t0, i, guard, max_lvl, stalls;
    bit  acc;
    do_reset();
    base = rx_q.size();
    t0   = timeouts;
    for (int j = 0; j < 18; j++) bytes[j] = 8'($urandom_range(0, 255));
    i = 0; guard = 0; max_lvl = 0; stalls = 0;
    tx_if.tx_data  = bytes[0];
    tx_if.tx_valid = 1'b1;
    while (i < 18 && guard < 4 * FRAME) begin
      tests++; if (tx_if.tx_ready !== (fifo_level != 5'd16)) begin fails++; $display("[TB] FAIL full_ready got %b at level %0d", tx_if.tx_ready, fifo_level); end
      if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
      acc = tx_if.tx_ready;
      if (!acc) stalls++;
      @(posedge clk); #1;
      guard++;
      if (acc) begin
        model_push(bytes[i]);
        i++;
        if (i < 18) tx_if.tx_data = bytes[i];
      end
    end
    tx_if.tx_valid = 1'b0;
    tests++; if (i != 18) begin fails++; $display("[TB] FAIL full_accepted got %0d want 18", i); end
    tests++; if (max_lvl != FIFO_DEPTH) begin fails++; $display("[TB] FAIL full_max_level got %0d want %0d", max_lvl, FIFO_DEPTH); end
    tests++; if (stalls == 0) begin fails++; $display("[TB] FAIL full_stall got %0d want >0", stalls); end
    wait_idle(20 * (FRAME + 1));
    tests++; if (rx_q.size() != base + exp_q.size()) begin fails++; $display("[TB] FAIL full_count got %0d want %0d", rx_q.size() - base, exp_q.size()); end
    else begin
      for (int j = 0; j < exp_q.size(); j++) begin
        tests++; if (rx_q[base + j] !== exp_q[j]) begin fails++; $display("[TB] FAIL full_byte%0d got %h want %h", j, rx_q[base + j], exp_q[j]); end
      end
    end
    tests++; if (timeouts != t0) begin fails++; $display("[TB] FAIL full_timeout got %0d want %0d", timeouts, t0); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b, c, d;
    int  base, t0;
    bit  went_low;
    do_reset();
    base = rx_q.size();
    t0   = timeouts;
    b = 8'($urandom_range(0, 127));
    c = 8'($urandom_range(0, 127));
    d = 8'($urandom_range(0, 127));
    push_byte(b);
    push_byte(c);
    idle_cycles(4 * DIV + DIV / 2 - 1);
    tests++; if (txd !== b[3]) begin fails++; $display("[TB] FAIL mid_bit3 got %b want %b", txd, b[3]); end
    tests++; if (fifo_level !== 5'd1) begin fails++; $display("[TB] FAIL mid_level_pre got %0d want 1", fifo_level); end
    #2;
    reset_n = 1'b0;
    #1;
    tests++; if (txd !== 1'b1) begin fails++; $display("[TB] FAIL mid_txd_async got %b want 1", txd); end
    tests++; if (fifo_level !== 5'd0) begin fails++; $display("[TB] FAIL mid_level_async got %0d want 0", fifo_level); end
    tests++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL mid_busy_async got %b want 0", busy); end
    idle_cycles(2);
    reset_n = 1'b1;
    exp_q.delete();
    model_last = 8'h00;
    went_low = 1'b0;
    for (int k = 0; k < FRAME + 2 * DIV; k++) begin
      @(posedge clk); #1;
      if (txd !== 1'b1 || busy !== 1'b0) went_low = 1'b1;
    end
    tests++; if (went_low) begin fails++; $display("[TB] FAIL mid_quiet got activity want idle"); end
    tests++; if (rx_q.size() != base) begin fails++; $display("[TB] FAIL mid_no_frame got %0d want 0", rx_q.size() - base); end
    push_byte(d);
    wait_idle(2 * FRAME);
    tests++; if (rx_q.size() != base + 1) begin fails++; $display("[TB] FAIL mid_after_count got %0d want 1", rx_q.size() - base); end
    else begin
      tests++; if (rx_q[base] !== d) begin fails++; $display("[TB] FAIL mid_after_byte got %h want %h", rx_q[base], d); end
    end
    tests++; if (timeouts != t0) begin fails++; $display("[TB] FAIL mid_timeout got %0d want %0d", timeouts, t0); end
  endtask

  task automatic test_running_status();
    logic [7:0] seq[12];
    logic [7:0] want[$];
    int base, t0;
    seq = '{8'h90, 8'h3C, 8'h7F, 8'h90, 8'h40, 8'h7F, 8'hF8, 8'h90, 8'h41, 8'hF0, 8'h90, 8'h42};
`ifdef MIDI_RUNNING_STATUS_EN
    want = '{8'h90, 8'h3C, 8'h7F, 8'h40, 8'h7F, 8'hF8, 8'h41, 8'hF0, 8'h90, 8'h42};
`else
    for (int i = 0; i < 12; i++) want.push_back(seq[i]);
`endif
    do_reset();
    base = rx_q.size();
    t0   = timeouts;
    for (int i = 0; i < 12; i++) push_byte(seq[i]);
    wait_idle(14 * (FRAME + 1));
    tests++; if (rx_q.size() != base + want.size()) begin fails++; $display("[TB] FAIL rs_count got %0d want %0d", rx_q.size() - base, want.size()); end
    else begin
      for (int i = 0; i < want.size(); i++) begin
        tests++; if (rx_q[base + i] !== want[i]) begin fails++; $display("[TB] FAIL rs_byte%0d got %h want %h", i, rx_q[base + i], want[i]); end
      end
    end
    tests++; if (timeouts != t0) begin fails++; $display("[TB] FAIL rs_timeout got %0d want %0d", timeouts, t0); end
  endtask

  task automatic test_random_stream();
    logic [7:0] b;
    int base, t0, fe0;
    do_reset();
    base = rx_q.size();
    t0   = timeouts;
    fe0  = frame_err;
    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 5))
        0:       b = 8'h90;
        1:       b = 8'h80 | 8'($urandom_range(0, 3));
        2:       b = 8'($urandom_range(0, 127));
        3:       b = 8'hF8 + 8'($urandom_range(0, 7));
        4:       b = 8'hF0 + 8'($urandom_range(0, 7));
        default: b = 8'($urandom_range(0, 255));
      endcase
      push_byte(b);
      if ($urandom_range(0, 7) == 0) idle_cycles($urandom_range(1, 2 * FRAME));
      else idle_cycles($urandom_range(0, 3));
    end
    wait_idle(26 * (FRAME + 1));
    tests++; if (rx_q.size() != base + exp_q.size()) begin fails++; $display("[TB] FAIL rand_count got %0d want %0d", rx_q.size() - base, exp_q.size()); end
    else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        tests++; if (rx_q[base + i] !== exp_q[i]) begin fails++; $display("[TB] FAIL rand_byte%0d got %h want %h", i, rx_q[base + i], exp_q[i]); end
      end
    end
    tests++; if (frame_err != fe0) begin fails++; $display("[TB] FAIL rand_framing got %0d want %0d", frame_err, fe0); end
    tests++; if (timeouts != t0) begin fails++; $display("[TB] FAIL rand_timeout got %0d want %0d", timeouts, t0); end
  endtask

  initial begin : main
    tx_if.tx_valid = 1'b0;
    tx_if.tx_data  = 8'h00;
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_full_fifo();
    test_reset_mid_frame();
    test_running_status();
    test_random_stream();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
